// File: rtl/avalon_sdram_req_buffer_if.sv
// rtl/avalon_sdram_req_buffer_if.sv - Avalon-MM command/response bundle
interface avalon_sdram_req_buffer_if #(
  parameter int AW   = 24,
  parameter int DW   = 16,
  parameter int BYTE = DW / 8
);
  logic            read;
  logic            write;
  logic [AW-1:0]   address;
  logic [DW-1:0]   writedata;
  logic [BYTE-1:0] byteenable;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;

  // master issues commands; slave stalls and returns read data
  modport master (
    output read, write, address, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_sdram_req_buffer.sv
// rtl/avalon_sdram_req_buffer.sv - command FIFO with read-outstanding limit in front of SDRAM controller
module avalon_sdram_req_buffer #(
  parameter int AW     = 24,
  parameter int DW     = 16,
  parameter int BYTE   = DW / 8,
  parameter int DEPTH  = 4,
  parameter int MAX_RD = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  avalon_sdram_req_buffer_if.slave  s,
  avalon_sdram_req_buffer_if.master m
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_RD + 1);

  logic            mem_is_write [DEPTH];
  logic [AW-1:0]   mem_address  [DEPTH];
  logic [DW-1:0]   mem_writedata[DEPTH];
  logic [BYTE-1:0] mem_byteen   [DEPTH];

  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [CW-1:0]   rd_cnt;
  logic            full;
  logic            empty;
  logic            rd_limit;
  logic            stall;
  logic            push;
  logic            push_read;
  logic            pop;
  logic [PW-1:0]   head;
  logic [DW-1:0]   readdata_q;
  logic            readdatavalid_q;

  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign rd_limit = (rd_cnt == CW'(MAX_RD));
  assign stall    = reset | full | rd_limit;

  // a simultaneous read+write is queued as the write alone
  assign push      = (s.read | s.write) & ~stall;
  assign push_read = push & ~s.write;
  assign pop       = ~empty & ~m.waitrequest;
  assign head      = rd_ptr[PW-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_is_write [wr_ptr[PW-1:0]] <= s.write;
      mem_address  [wr_ptr[PW-1:0]] <= s.address;
      mem_writedata[wr_ptr[PW-1:0]] <= s.writedata;
      mem_byteen   [wr_ptr[PW-1:0]] <= s.byteenable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // a stray readdatavalid with nothing outstanding leaves the count at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
    end else begin
      case ({push_read, m.readdatavalid})
        2'b10:   rd_cnt <= rd_cnt + CW'(1);
        2'b01:   if (rd_cnt != '0) rd_cnt <= rd_cnt - CW'(1);
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
    end else begin
      readdatavalid_q <= m.readdatavalid;
      if (m.readdatavalid) readdata_q <= m.readdata;
    end
  end

  assign s.waitrequest   = stall;
  assign s.readdata      = readdata_q;
  assign s.readdatavalid = readdatavalid_q;

  assign m.write      = ~empty & mem_is_write[head];
  assign m.read       = ~empty & ~mem_is_write[head];
  assign m.address    = mem_address[head];
  assign m.writedata  = mem_writedata[head];
  assign m.byteenable = mem_byteen[head];
endmodule

// File: tb/tb_avalon_sdram_req_buffer.sv
// tb/tb_avalon_sdram_req_buffer.sv - directed self-checking bench for avalon_sdram_req_buffer
module tb_avalon_sdram_req_buffer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   acc;
  int   mrd;

  avalon_sdram_req_buffer_if #(.AW(24), .DW(16)) s_if ();
  avalon_sdram_req_buffer_if #(.AW(24), .DW(16)) m_if ();

  avalon_sdram_req_buffer #(.AW(24), .DW(16), .DEPTH(4), .MAX_RD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s_if.slave),
    .m     (m_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    s_if.read       = 1'b0;
    s_if.write      = 1'b0;
    s_if.address    = '0;
    s_if.writedata  = '0;
    s_if.byteenable = '0;
  endtask

  task automatic drive_cmd(input logic rd, input logic wr, input logic [23:0] a, input logic [15:0] d);
    s_if.read       = rd;
    s_if.write      = wr;
    s_if.address    = a;
    s_if.writedata  = d;
    s_if.byteenable = 2'b11;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive_idle();
    m_if.waitrequest   = 1'b0;
    m_if.readdata      = '0;
    m_if.readdatavalid = 1'b0;

    // reset state
    next_cycle();
    @(negedge clk);
    check("rst_wait", s_if.waitrequest, 1);
    check("rst_mread", m_if.read, 0);
    check("rst_mwrite", m_if.write, 0);
    check("rst_srdv", s_if.readdatavalid, 0);
    check("rst_srd", s_if.readdata, 0);
    check("rst_rdcnt", dut.rd_cnt, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_wait", s_if.waitrequest, 0);

    // single write, visible the cycle after acceptance for exactly one cycle
    next_cycle();
    s_if.read = 1'b0; s_if.write = 1'b1; s_if.address = 24'h000010;
    s_if.writedata = 16'hBEEF; s_if.byteenable = 2'b11;
    @(negedge clk);
    check("w1_wait", s_if.waitrequest, 0);
    check("w1_nobypass", m_if.write, 0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("w1_mwrite", m_if.write, 1);
    check("w1_addr", m_if.address, 24'h000010);
    check("w1_data", m_if.writedata, 16'hBEEF);
    check("w1_be", m_if.byteenable, 2'b11);
    check("w1_wait2", s_if.waitrequest, 0);
    next_cycle();
    @(negedge clk);
    check("w1_done", m_if.write, 0);

    // fill to DEPTH with controller stalled, fifth write waits
    next_cycle();
    m_if.waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b0, 1'b1, 24'(i), 16'(16'h1000 + i));
      @(negedge clk);
      check($sformatf("full_wait%0d", i), s_if.waitrequest, (i == 4) ? 1 : 0);
      next_cycle();
    end
    m_if.waitrequest = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("drain_mw%0d", k), m_if.write, 1);
      check($sformatf("drain_a%0d", k), m_if.address, k);
      check($sformatf("drain_d%0d", k), m_if.writedata, 32'h1000 + k);
      if (k == 0) check("drain_wait_hi", s_if.waitrequest, 1);
      if (k == 1) check("drain_wait_lo", s_if.waitrequest, 0);
      next_cycle();
      if (k == 1) drive_idle();
    end
    @(negedge clk);
    check("drain_empty", m_if.write, 0);

    // outstanding-read limit
    next_cycle();
    acc = 0;
    mrd = 0;
    drive_cmd(1'b1, 1'b0, 24'h100, 16'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_if.read) mrd++;
      if (!s_if.waitrequest) acc++;
      next_cycle();
      s_if.address = 24'(24'h100 + acc);
    end
    check("lim_accepted", acc, 8);
    check("lim_mreads", mrd, 8);
    m_if.readdatavalid = 1'b1;
    m_if.readdata      = 16'h1234;
    @(negedge clk);
    check("lim_wait", s_if.waitrequest, 1);
    check("lim_rdcnt", dut.rd_cnt, 8);
    check("lim_srdv_early", s_if.readdatavalid, 0);
    next_cycle();
    m_if.readdatavalid = 1'b0;
    @(negedge clk);
    check("lim_srdv", s_if.readdatavalid, 1);
    check("lim_srd", s_if.readdata, 16'h1234);
    check("lim_wait_lo", s_if.waitrequest, 0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("lim_wait_again", s_if.waitrequest, 1);
    check("lim_srdv_off", s_if.readdatavalid, 0);
    check("lim_srd_held", s_if.readdata, 16'h1234);
    check("lim_9th_mread", m_if.read, 1);
    check("lim_9th_addr", m_if.address, 24'h108);
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      m_if.readdatavalid = 1'b1;
    end
    next_cycle();
    m_if.readdatavalid = 1'b0;
    @(negedge clk);
    check("lim_rdcnt_zero", dut.rd_cnt, 0);

    // interleaved R, W, R with in-order data return
    next_cycle();
    drive_cmd(1'b1, 1'b0, 24'h200, 16'h0);
    next_cycle();
    drive_cmd(1'b0, 1'b1, 24'h201, 16'hBBBB);
    @(negedge clk);
    check("il_r1", {m_if.read, m_if.write}, 2'b10);
    check("il_a1", m_if.address, 24'h200);
    next_cycle();
    drive_cmd(1'b1, 1'b0, 24'h202, 16'h0);
    @(negedge clk);
    check("il_w", {m_if.read, m_if.write}, 2'b01);
    check("il_a2", m_if.address, 24'h201);
    check("il_d2", m_if.writedata, 16'hBBBB);
    next_cycle();
    drive_idle();
    m_if.readdatavalid = 1'b1;
    m_if.readdata      = 16'hAAAA;
    @(negedge clk);
    check("il_r3", {m_if.read, m_if.write}, 2'b10);
    check("il_a3", m_if.address, 24'h202);
    check("il_srdv0", s_if.readdatavalid, 0);
    next_cycle();
    m_if.readdata = 16'hCCCC;
    @(negedge clk);
    check("il_srdv1", s_if.readdatavalid, 1);
    check("il_srd1", s_if.readdata, 16'hAAAA);
    next_cycle();
    m_if.readdatavalid = 1'b0;
    @(negedge clk);
    check("il_srdv2", s_if.readdatavalid, 1);
    check("il_srd2", s_if.readdata, 16'hCCCC);
    next_cycle();
    @(negedge clk);
    check("il_srdv3", s_if.readdatavalid, 0);
    check("il_rdcnt", dut.rd_cnt, 0);

    // read and write together: write wins
    next_cycle();
    drive_cmd(1'b1, 1'b1, 24'h300, 16'h5A5A);
    @(negedge clk);
    check("rw_wait", s_if.waitrequest, 0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("rw_kind", {m_if.read, m_if.write}, 2'b01);
    check("rw_addr", m_if.address, 24'h300);
    check("rw_rdcnt", dut.rd_cnt, 0);
    next_cycle();
    @(negedge clk);
    check("rw_single", {m_if.read, m_if.write}, 2'b00);

    // reset mid-operation with queued commands and outstanding reads
    next_cycle();
    m_if.waitrequest = 1'b1;
    drive_cmd(1'b1, 1'b0, 24'h400, 16'h0);
    next_cycle();
    drive_cmd(1'b1, 1'b0, 24'h401, 16'h0);
    next_cycle();
    drive_cmd(1'b0, 1'b1, 24'h402, 16'h9999);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("mr_rdcnt2", dut.rd_cnt, 2);
    check("mr_head", m_if.read, 1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("mr_wait_rst", s_if.waitrequest, 1);
    next_cycle();
    reset = 1'b0;
    m_if.readdatavalid = 1'b1;
    m_if.readdata      = 16'h7777;
    @(negedge clk);
    check("mr_idle", {m_if.read, m_if.write}, 2'b00);
    check("mr_wait_lo", s_if.waitrequest, 0);
    check("mr_rdcnt0", dut.rd_cnt, 0);
    next_cycle();
    m_if.readdatavalid = 1'b0;
    @(negedge clk);
    check("mr_fwd_v", s_if.readdatavalid, 1);
    check("mr_fwd_d", s_if.readdata, 16'h7777);
    check("mr_no_underflow", dut.rd_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/avalon_sdram_req_buffer.md
# avalon_sdram_req_buffer

Request buffer between an Avalon-MM master (CPU/DMA) and the Avalon slave port of the SDRAM controller. It decouples the master from controller stalls during init, refresh, and row changes by queueing up to DEPTH read/write commands in a FIFO. It limits the number of outstanding reads to MAX_RD and returns read data to the master in order with one registered stage.

## Interface

- AW, 24: Avalon word-address width
- DW, 16: data width
- BYTE, DW/8: byteenable width
- DEPTH, 4: command FIFO depth; power of two, ≥2
- MAX_RD, 8: maximum reads accepted but not yet returned; ≥1

- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_read  input  1  master read request
- s_write  input  1  master write request
- s_address  input  AW  master address
- s_writedata  input  DW  master write data
- s_byteenable  input  BYTE  master byte enables
- s_waitrequest  output  1  stall to master
- s_readdata  output  DW  read data to master
- s_readdatavalid  output  1  read data valid to master
- m_read  output  1  read command to controller
- m_write  output  1  write command to controller
- m_address  output  AW  address to controller
- m_writedata  output  DW  write data to controller
- m_byteenable  output  BYTE  byte enables to controller
- m_waitrequest  input  1  controller stall
- m_readdata  input  DW  controller read data
- m_readdatavalid  input  1  controller read data valid

## Operation

- FIFO entry: {is_write, address, writedata, byteenable}. Registered storage, wr_ptr/rd_ptr of log2(DEPTH)+1 bits.
- Full when the pointer MSBs differ and the low bits are equal. Empty when the pointers are equal.
- s_waitrequest = reset | full | (rd_cnt == MAX_RD). The output is independent of s_read/s_write.
- Accept (push) when (s_read | s_write) & !s_waitrequest.
  - If s_write is high, the entry is a write. Read+write together is illegal; write wins and the read is dropped.
- Master side is driven combinationally from the FIFO head:
  - m_write = !empty & head.is_write
  - m_read = !empty & !head.is_write
  - m_address, m_writedata, m_byteenable = head fields
- Pop when !empty & !m_waitrequest.
- There is no bypass: an empty FIFO presents nothing in the push cycle.
- Push and pop in the same cycle are both allowed when neither full nor empty. Occupancy stays unchanged.
- rd_cnt (width clog2(MAX_RD+1)):
  - +1 on an accepted read.
  - −1 on m_readdatavalid.
  - Both in the same cycle: unchanged.
  - m_readdatavalid with rd_cnt==0: data is still forwarded and the counter holds at 0 (no underflow).
- Read return: s_readdatavalid <= m_readdatavalid; s_readdata <= m_readdata when m_readdatavalid, otherwise held.
- Writes produce no response.

## Timing

- Reset values:
  - Pointers and rd_cnt: 0.
  - s_readdatavalid: 0; s_readdata: 0.
  - m_read, m_write: 0 (FIFO empty).
  - s_waitrequest: 1 while reset is high.
- Command latency: accepted at edge N, visible on m_* in cycle N+1. Held stable until popped.
- Read data latency: m_readdatavalid at edge N gives s_readdatavalid in cycle N+1.
- Back-to-back: with m_waitrequest low, one command per cycle is sustained. Throughput is 1/cycle after the first.
- Full: s_waitrequest rises in the cycle after the DEPTH-th accept. It falls in the cycle after the first pop.
- Read limit: after the MAX_RD-th outstanding read is accepted, s_waitrequest stays high until the first m_readdatavalid is registered. Writes are also stalled during this time.
- Reset mid-operation: queued commands and outstanding-read tracking are discarded. m_* go idle the cycle after reset is sampled. Data returning from the controller after reset is still forwarded on s_readdatavalid.

## Test plan

- Reset, then a single write (addr 0x000010, data 0xBEEF, be 2'b11) with m_waitrequest=0 -> m_write high for exactly 1 cycle at N+1 with the same fields; s_waitrequest low throughout.
- Hold m_waitrequest=1 and issue 5 writes, DEPTH=4 -> 4 accepted, s_waitrequest=1 from the 5th attempt. Release m_waitrequest -> entries drain in order, the 5th is accepted after the first pop, all data matches.
- Issue 9 reads with MAX_RD=8 and the controller returning nothing -> 8 accepted (FIFO drains to the controller), s_waitrequest stays high. One m_readdatavalid (0x1234) -> s_readdatavalid+0x1234 the next cycle, and the 9th read is accepted the cycle after.
- Interleave read A, write B, read C with controller data 0xAAAA, 0xCCCC -> m_ order is R,W,R; s_readdata order is 0xAAAA then 0xCCCC, each delayed by one cycle.
- Assert s_read and s_write together -> a single write is queued and rd_cnt is unchanged.
- Assert reset with 3 entries queued and rd_cnt=2 -> next cycle empty, m_read=m_write=0, s_waitrequest=1 during reset and 0 after, rd_cnt=0.
